// File: rtl/cla_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder.
//   CLA_WIDTH / CLA_SLICE : default operand width and bits resolved per stage
//   stage_t               : per-stage pipeline record
//   grp_combine           : merges a high and a low group propagate/generate
package cla_pkg;

    localparam int unsigned CLA_WIDTH = 64;
    localparam int unsigned CLA_SLICE = 16;

    // x/y ride along so later stages can reach their slices; d fills in
    // from the bottom one slice per stage; carry is the carry out of the
    // highest slice resolved so far.
    typedef struct packed {
        logic                 valid;
        logic [CLA_WIDTH-1:0] x;
        logic [CLA_WIDTH-1:0] y;
        logic [CLA_WIDTH-1:0] d;
        logic                 carry;
        logic                 gp;
        logic                 gg;
    } stage_t;

    // Returns {p, g} for the concatenation {hi, lo}.
    function automatic logic [1:0] grp_combine(input logic p_hi, input logic g_hi,
                                               input logic p_lo, input logic g_lo);
        return {p_hi & p_lo, g_hi | (p_hi & g_lo)};
    endfunction

endpackage

// File: rtl/cla_slice16.sv
// Combinational 16-bit carry-lookahead adder slice.
//   a, b : operands
//   ci   : carry in
//   s    : sum
//   co   : carry out
//   p, g : group propagate / generate of the full slice (independent of ci)
// Four 4-bit lookahead groups, with a second lookahead level across the groups.
module cla_slice16 import cla_pkg::*; (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        ci,
    output logic [15:0] s,
    output logic        co,
    output logic        p,
    output logic        g
);

    logic [15:0] bp;
    logic [15:0] bg;
    logic [15:0] c;
    logic [3:0]  gp4;
    logic [3:0]  gg4;
    logic [3:0]  cg;

    // Carries into bits 0..3 of a 4-wide lookahead block.
    function automatic logic [3:0] carries4(input logic [3:0] pp, input logic [3:0] gg,
                                            input logic c0);
        logic [3:0] cc;
        cc[0] = c0;
        cc[1] = gg[0] | (pp[0] & c0);
        cc[2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & c0);
        cc[3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0])
              | (pp[2] & pp[1] & pp[0] & c0);
        return cc;
    endfunction

    assign bp = a ^ b;
    assign bg = a & b;

    // Group and slice propagate/generate.
    always_comb begin
        logic [1:0] hi;
        logic [1:0] lo;
        gp4 = '0;
        gg4 = '0;
        hi  = '0;
        lo  = '0;
        for (int unsigned j = 0; j < 4; j++) begin
            hi = grp_combine(bp[4*j+3], bg[4*j+3], bp[4*j+2], bg[4*j+2]);
            lo = grp_combine(bp[4*j+1], bg[4*j+1], bp[4*j],   bg[4*j]);
            {gp4[j], gg4[j]} = grp_combine(hi[1], hi[0], lo[1], lo[0]);
        end
        hi = grp_combine(gp4[3], gg4[3], gp4[2], gg4[2]);
        lo = grp_combine(gp4[1], gg4[1], gp4[0], gg4[0]);
        {p, g} = grp_combine(hi[1], hi[0], lo[1], lo[0]);
    end

    // Second-level carries into each group, then bit carries inside groups.
    always_comb begin
        c  = '0;
        cg = carries4(gp4, gg4, ci);
        for (int unsigned j = 0; j < 4; j++) begin
            c[4*j +: 4] = carries4(bp[4*j +: 4], bg[4*j +: 4], cg[j]);
        end
        s  = bp ^ c;
        co = g | (p & ci);
    end

endmodule

// File: rtl/cla_adder_pipe64.sv
// Pipelined 64-bit carry-lookahead adder: {cout, d} = x + y + cin.
//   clk, rst_n           : clock (rising edge), synchronous active-low reset
//   in_valid / in_ready  : input handshake for x, y, cin
//   out_valid / out_ready: output handshake for d, cout, ovf, GP, GG
//   d, cout              : sum and carry out of bit WIDTH-1
//   ovf                  : signed overflow
//   GP, GG               : whole-word group propagate/generate (0 when !out_valid)
// One SLICE-wide lookahead slice per stage, one add per cycle, whole pipe
// advances together whenever the output register is free or being drained.
module cla_adder_pipe64 import cla_pkg::*; #(
    parameter int unsigned WIDTH = CLA_WIDTH,
    parameter int unsigned SLICE = CLA_SLICE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             cout,
    output logic             ovf,
    output logic             GP,
    output logic             GG
);

    localparam int unsigned STAGES = WIDTH / SLICE;

    stage_t in_rec;
    stage_t st_q [STAGES];
    stage_t st_d [STAGES];
    logic   adv;

    // gp=1/gg=0 is the identity for grp_combine, so stage 0 folds in like the rest.
    always_comb begin
        in_rec       = '0;
        in_rec.valid = in_valid;
        in_rec.x     = x;
        in_rec.y     = y;
        in_rec.carry = cin;
        in_rec.gp    = 1'b1;
        in_rec.gg    = 1'b0;
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        stage_t           prev;
        stage_t           nxt;
        logic [SLICE-1:0] s;
        logic             co;
        logic             p;
        logic             g;

        if (k == 0) begin : g_first
            assign prev = in_rec;
        end else begin : g_rest
            assign prev = st_q[k-1];
        end

        cla_slice16 u_slice (
            .a  (prev.x[k*SLICE +: SLICE]),
            .b  (prev.y[k*SLICE +: SLICE]),
            .ci (prev.carry),
            .s  (s),
            .co (co),
            .p  (p),
            .g  (g)
        );

        always_comb begin
            nxt                     = prev;
            nxt.d[k*SLICE +: SLICE] = s;
            nxt.carry               = co;
            {nxt.gp, nxt.gg}        = grp_combine(p, g, prev.gp, prev.gg);
        end

        assign st_d[k] = nxt;
    end

    // Bubbles only move the valid bit, so the output data holds its last
    // result while the pipe runs empty.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                st_q[k] <= '0;
            end
        end else if (adv) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                if (st_d[k].valid) begin
                    st_q[k] <= st_d[k];
                end else begin
                    st_q[k].valid <= 1'b0;
                end
            end
        end
    end

    assign out_valid = st_q[STAGES-1].valid;
    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv;
    assign d         = st_q[STAGES-1].d;
    assign cout      = st_q[STAGES-1].carry;
    assign ovf       = (st_q[STAGES-1].x[WIDTH-1] == st_q[STAGES-1].y[WIDTH-1])
                    && (st_q[STAGES-1].d[WIDTH-1] != st_q[STAGES-1].x[WIDTH-1]);
    assign GP        = out_valid & st_q[STAGES-1].gp;
    assign GG        = out_valid & st_q[STAGES-1].gg;

endmodule
